mux_scan_n: RTL and testbench



---
 rtl/mux_scan_n.sv | 73 +++++++
 tb/tb_mux_scan_n.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mux_scan_n.sv
// N-channel registered multiplexer with manual select and an auto-scan mode
// that steps through channels with a programmable dwell and a hold control.
module mux_scan_n #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 1,
  parameter int SEL_W    = 2,
  parameter int DWELL_W  = 26
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic                      hold,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          chan_out,
  output logic                      switched
);

  localparam logic [SEL_W:0]     CHAN_LIM = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0]   LAST_IDX = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W-1:0]   ONE_S    = SEL_W'(1);
  localparam logic [DWELL_W-1:0] ONE_C    = DWELL_W'(1);

  logic [SEL_W-1:0]   cur_q, cur_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               switched_q, switched_d;

  always_comb begin
    cur_d = cur_q;
    cnt_d = cnt_q;
    if (!mode) begin
      // Out-of-range manual selects keep the current channel rather than wrap.
      if ({1'b0, sel} < CHAN_LIM) cur_d = sel;
      cnt_d = '0;
    end else if (!hold) begin
      // >= rather than == so lowering dwell below cnt advances immediately.
      if (cnt_q >= dwell) begin
        cnt_d = '0;
        cur_d = (cur_q == LAST_IDX) ? '0 : cur_q + ONE_S;
      end else begin
        cnt_d = cnt_q + ONE_C;
      end
    end

    data_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cur_d == SEL_W'(k)) data_d = data_in[k*WIDTH +: WIDTH];
    end
    switched_d = (cur_d != cur_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      switched_q <= 1'b0;
    end else begin
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      switched_q <= switched_d;
    end
  end

  assign data_out = data_q;
  assign chan_out = cur_q;
  assign switched = switched_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Randomised scoreboard bench for mux_scan_n: a driver pushes the expected
// registered outputs for each edge, a monitor pops and compares after the edge.
module tb_mux_scan_n;

  localparam int CH = 3;
  localparam int W  = 8;
  localparam int SW = 2;
  localparam int DW = 6;
  localparam int EW = W + SW + 1;

  logic              clock = 1'b0;
  logic              reset;
  logic [CH*W-1:0]   data_in;
  logic [SW-1:0]     sel;
  logic              mode;
  logic [DW-1:0]     dwell;
  logic              hold;
  logic [W-1:0]      data_out;
  logic [SW-1:0]     chan_out;
  logic              switched;

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int m_cur = 0;
  int m_cnt = 0;

  mux_scan_n #(.CHANNELS(CH), .WIDTH(W), .SEL_W(SW), .DWELL_W(DW)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .sel(sel), .mode(mode),
    .dwell(dwell), .hold(hold), .data_out(data_out), .chan_out(chan_out),
    .switched(switched)
  );

  // clock / reset
  always #5 clock = ~clock;

  // driver: applies one cycle of stimulus and predicts the outputs after the next edge
  task automatic drive(input logic r, input logic m, input logic h, input int d, input int s);
    int nc;
    logic [W-1:0] ed;
    logic esw;
    @(negedge clock);
    reset = r; mode = m; hold = h; dwell = DW'(d); sel = SW'(s);
    for (int k = 0; k < CH; k++) data_in[k*W +: W] = W'($urandom_range(0, 255));
    if (r) begin
      m_cur = 0; m_cnt = 0;
      exp_q.push_back({W'(0), SW'(0), 1'b0});
    end else begin
      if (!m) begin
        nc = (s < CH) ? s : m_cur;
        m_cnt = 0;
      end else if (h) begin
        nc = m_cur;
      end else if (m_cnt >= d) begin
        m_cnt = 0;
        nc = (m_cur + 1) % CH;
      end else begin
        m_cnt = m_cnt + 1;
        nc = m_cur;
      end
      ed  = data_in[nc*W +: W];
      esw = (nc != m_cur);
      m_cur = nc;
      exp_q.push_back({ed, SW'(nc), esw});
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // monitor: every edge presents a new registered output set
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("data_out", int'(data_out), int'(e[EW-1 -: W]));
        chk("chan_out", int'(chan_out), int'(e[SW:1]));
        chk("switched", int'(switched), int'(e[0]));
      end
    end
  end

  initial begin
    reset = 1'b1; mode = 1'b0; hold = 1'b0; dwell = '0; sel = '0; data_in = '0;
    repeat (3) drive(1, 0, 0, 0, 0);

    // manual sweep including an out-of-range select and a repeated select
    for (int s = 0; s < 4; s++) drive(0, 0, 0, 0, s);
    drive(0, 0, 0, 0, 2);
    drive(0, 0, 0, 0, 3);
    drive(0, 0, 0, 0, 3);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // auto-scan from reset with dwell=2, two full sweeps
    drive(1, 1, 0, 2, 0);
    repeat (18) drive(0, 1, 0, 2, 0);

    // hold for 5 cycles at cnt=1, then release
    drive(1, 1, 0, 2, 0);
    drive(0, 1, 0, 2, 0);
    repeat (5) drive(0, 1, 1, 2, 0);
    repeat (6) drive(0, 1, 0, 2, 0);

    // dwell lowered 10 -> 1 while cnt=7
    drive(1, 1, 0, 10, 0);
    repeat (7) drive(0, 1, 0, 10, 0);
    repeat (5) drive(0, 1, 0, 1, 0);

    // dwell=0 advances every edge
    repeat (6) drive(0, 1, 0, 0, 0);

    // scan to channel 2, switch to manual sel=0, then back to scan
    drive(1, 1, 0, 1, 0);
    repeat (4) drive(0, 1, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    repeat (5) drive(0, 1, 0, 1, 0);

    // reset mid-scan
    drive(1, 1, 0, 7, 0);
    repeat (3 * 8 - 3) drive(0, 1, 0, 7, 0);
    drive(1, 1, 0, 7, 0);
    repeat (10) drive(0, 1, 0, 7, 0);

    // random mix
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 4) == 0), $urandom_range(0, 5), $urandom_range(0, 3));
    end

    @(posedge clock);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
